// File: rtl/serial_fifo_pkg.sv
// serial_fifo_pkg: shared definitions for the FIFO-based UART controller.
//   - register offsets (addr_i values)
//   - STATUS / CTRL bit positions
//   - TX FSM state encoding
//   - CLOG2 helper used to size FIFO pointers
package serial_fifo_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_CLEAR  = 2'd3;

   // STATUS fields
   localparam int ST_TX_NFULL   = 0;
   localparam int ST_RX_NEMPTY  = 1;
   localparam int ST_RX_OVR     = 2;
   localparam int ST_TX_OVF     = 3;
   localparam int ST_RX_CNT_LSB = 8;
   localparam int ST_TX_CNT_LSB = 16;

   // CTRL fields
   localparam int CT_RX_IE   = 0;
   localparam int CT_TX_IE   = 1;
   localparam int CT_THR_LSB = 8;

   localparam logic [3:0] RX_THRESH_RST = 4'd1;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_GUARD = 2'd2,
      TX_WAIT  = 2'd3
   } tx_state_t;

   function automatic int CLOG2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_fifo_ctrl_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   push/din  - write request, ignored when full
//   pop       - read request, ignored when empty
//   dout      - head entry, shown combinationally
//   full/empty/count - occupancy from pointers that carry one extra wrap bit
// Storage is deliberately not reset; only the pointers are.
module sync_fifo
   import serial_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [CLOG2(DEPTH):0]    count
);

   localparam int AW = CLOG2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr;
   logic [AW:0]      r_rd;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_push_ok = push & ~full;
   assign w_pop_ok  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
         if (w_pop_ok)  r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr[AW-1:0]] <= din;
   end

   // Extra MSB distinguishes full from empty when the index bits match.
   assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign empty = (r_wr == r_rd);
   assign count = r_wr - r_rd;
   assign dout  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/serial_fifo_ctrl.sv
// serial_fifo_ctrl: memory-mapped UART controller with RX/TX FIFOs.
//   CPU side : enable_i, readEnable_i, addr_i, dataSave_i -> dataLoad_o
//   IRQ      : int_o (registered, COM bit)
//   RX side  : rxdReady_i pulse + rxdData_i from async_receiver
//   TX side  : txdStart_o strobe + txdData_o to async_transmitter, txdBusy_i back
module serial_fifo_ctrl
   import serial_fifo_pkg::*;
#(
   parameter int RX_DEPTH = 16,
   parameter int TX_DEPTH = 16,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic              readEnable_i,
   input  logic [1:0]        addr_i,
   input  logic [31:0]       dataSave_i,
   output logic [31:0]       dataLoad_o,
   output logic              int_o,
   input  logic              rxdReady_i,
   input  logic [DATA_W-1:0] rxdData_i,
   input  logic              txdBusy_i,
   output logic              txdStart_o,
   output logic [DATA_W-1:0] txdData_o
);

   localparam int RX_AW = CLOG2(RX_DEPTH);
   localparam int TX_AW = CLOG2(TX_DEPTH);

   logic              r_enable_q;
   logic              w_acc, w_rd_acc, w_wr_acc;
   logic              w_rx_pop, w_tx_push, w_ctrl_wr, w_clr_wr;
   logic              w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
   logic [RX_AW:0]    w_rx_count;
   logic [TX_AW:0]    w_tx_count;
   logic [7:0]        w_rx_cnt8, w_tx_cnt8;
   logic [DATA_W-1:0] w_rx_dout, w_tx_dout;
   logic              w_tx_pop;
   logic              r_rx_ie, r_tx_ie, r_rx_ovr, r_tx_ovf, r_int;
   logic [3:0]        r_rx_thresh, w_thr_eff;
   logic              w_int_nxt;
   logic [31:0]       w_load;
   logic [DATA_W-1:0] r_txd_data;
   tx_state_t         r_state, w_state_nxt;

   // One side effect per CPU access even though enable_i is held.
   assign w_acc     = enable_i & ~r_enable_q;
   assign w_rd_acc  = w_acc & readEnable_i;
   assign w_wr_acc  = w_acc & ~readEnable_i;
   assign w_rx_pop  = w_rd_acc & (addr_i == REG_DATA);
   assign w_tx_push = w_wr_acc & (addr_i == REG_DATA);
   assign w_ctrl_wr = w_wr_acc & (addr_i == REG_CTRL);
   assign w_clr_wr  = w_wr_acc & (addr_i == REG_CLEAR);

   sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push(rxdReady_i), .pop(w_rx_pop),
      .din(rxdData_i), .dout(w_rx_dout), .full(w_rx_full),
      .empty(w_rx_empty), .count(w_rx_count)
   );

   sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push(w_tx_push), .pop(w_tx_pop),
      .din(dataSave_i[DATA_W-1:0]), .dout(w_tx_dout), .full(w_tx_full),
      .empty(w_tx_empty), .count(w_tx_count)
   );

   assign w_rx_cnt8 = 8'(w_rx_count);
   assign w_tx_cnt8 = 8'(w_tx_count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enable_q  <= 1'b0;
         r_rx_ie     <= 1'b0;
         r_tx_ie     <= 1'b0;
         r_rx_thresh <= RX_THRESH_RST;
         r_rx_ovr    <= 1'b0;
         r_tx_ovf    <= 1'b0;
         r_int       <= 1'b0;
      end else begin
         r_enable_q <= enable_i;
         if (w_ctrl_wr) begin
            r_rx_ie     <= dataSave_i[CT_RX_IE];
            r_tx_ie     <= dataSave_i[CT_TX_IE];
            r_rx_thresh <= dataSave_i[CT_THR_LSB +: 4];
         end
         // A new error in the same cycle as its clear wins, so no event is lost.
         r_rx_ovr <= (rxdReady_i & w_rx_full) |
                     (r_rx_ovr & ~(w_clr_wr & dataSave_i[ST_RX_OVR]));
         r_tx_ovf <= (w_tx_push & w_tx_full) |
                     (r_tx_ovf & ~(w_clr_wr & dataSave_i[ST_TX_OVF]));
         r_int    <= w_int_nxt;
      end
   end

   // A threshold of 0 behaves like 1 so an enabled RX irq never fires on empty.
   assign w_thr_eff = (r_rx_thresh == 4'd0) ? 4'd1 : r_rx_thresh;
   assign w_int_nxt = (r_rx_ie & ((w_rx_cnt8 >= {4'd0, w_thr_eff}) | r_rx_ovr)) |
                      (r_tx_ie & w_tx_empty & (r_state == TX_IDLE));
   assign int_o     = r_int;

   always_comb begin
      w_load = '0;
      case (addr_i)
         REG_DATA:   if (!w_rx_empty) w_load[DATA_W-1:0] = w_rx_dout;
         REG_STATUS: begin
            w_load[ST_TX_NFULL]          = ~w_tx_full;
            w_load[ST_RX_NEMPTY]         = ~w_rx_empty;
            w_load[ST_RX_OVR]            = r_rx_ovr;
            w_load[ST_TX_OVF]            = r_tx_ovf;
            w_load[ST_RX_CNT_LSB +: 8]   = w_rx_cnt8;
            w_load[ST_TX_CNT_LSB +: 8]   = w_tx_cnt8;
         end
         REG_CTRL: begin
            w_load[CT_RX_IE]             = r_rx_ie;
            w_load[CT_TX_IE]             = r_tx_ie;
            w_load[CT_THR_LSB +: 4]      = r_rx_thresh;
         end
         default: ;
      endcase
   end
   assign dataLoad_o = w_load;

   // TX FSM state register and output data latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= TX_IDLE;
         r_txd_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_tx_pop) r_txd_data <= w_tx_dout;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tx_pop    = 1'b0;
      case (r_state)
         TX_IDLE: if (!w_tx_empty && !txdBusy_i) begin
            w_tx_pop    = 1'b1;
            w_state_nxt = TX_START;
         end
         TX_START: w_state_nxt = TX_GUARD;
         // Transmitter needs a cycle before txdBusy_i reflects the new frame.
         TX_GUARD: w_state_nxt = TX_WAIT;
         TX_WAIT:  if (!txdBusy_i) w_state_nxt = TX_IDLE;
         default:  w_state_nxt = TX_IDLE;
      endcase
   end

   assign txdStart_o = (r_state == TX_START);
   assign txdData_o  = r_txd_data;

endmodule
